// File: rtl/fpu_core.sv
// ---------------------------------------------------------------------------
// fpu_core
//   Floating-point helper coprocessor. It holds 32 single-precision
//   registers and executes one operation per request. The operations are:
//     - immediate load (SET)
//     - Newton-iteration seed generators for reciprocal, sqrt and 1/sqrt
//     - compares that drive a condition flag
//   A request is accepted when ready is high in IDLE. The result is
//   registered, and valid pulses for one cycle on the following cycle.
//
// Ports
//   clk        in   1   clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   x1, x2     in   5   source register addresses
//   y          in   5   destination register address
//   operation  in   6   opcode
//   in_data    in  32   immediate for SET
//   ready      in   1   request strobe (operands/opcode valid)
//   valid      out  1   one-cycle completion pulse
//   out_data   out 32   result of the last operation
//   cond       out  1   result of the last compare
//
// Build option
//   FPU_ZERO_REG_EN : when defined, register 0 reads as +0 and writes to
//                     y=0 are dropped. out_data and valid still report the
//                     computed value.
// ---------------------------------------------------------------------------
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for ready; accepts and executes an op in one edge
// ST_DONE  | valid is high this cycle; ready ignored; returns to ST_IDLE
// ---------------------------------------------------------------------------
module fpu_core (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  x1,
    input  logic [4:0]  x2,
    input  logic [4:0]  y,
    input  logic [5:0]  operation,
    input  logic [31:0] in_data,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] out_data,
    output logic        cond
);

    localparam logic [5:0] FPU_OPFCLT          = 6'b000100;
    localparam logic [5:0] FPU_OPFCZ           = 6'b000101;
    localparam logic [5:0] FPU_OPFINV_INIT     = 6'b010000;
    localparam logic [5:0] FPU_OPSQRT_INIT     = 6'b010001;
    localparam logic [5:0] FPU_OPSQRT_INV_INIT = 6'b010010;
    localparam logic [5:0] FPU_OPSET           = 6'b111110;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        valid_q, valid_d;
    logic        cond_q, cond_d;
    logic [31:0] out_data_q, out_data_d;

    // Operand read and classification
    logic [31:0] opa, opb;
    logic        a_sign, b_sign;
    logic        a_exp_zero, a_exp_max, a_man_zero;
    logic        a_inf, a_nan, b_nan;
    logic        a_lt_b;

    always_comb begin
        opa = regs_q[x1];
        opb = regs_q[x2];
`ifdef FPU_ZERO_REG_EN
        if (x1 == 5'd0) opa = '0;
        if (x2 == 5'd0) opb = '0;
`endif
        a_sign     = opa[31];
        b_sign     = opb[31];
        a_exp_zero = (opa[30:23] == 8'h00);
        a_exp_max  = (opa[30:23] == 8'hFF);
        a_man_zero = (opa[22:0] == 23'd0);
        a_inf      = a_exp_max && a_man_zero;
        a_nan      = a_exp_max && !a_man_zero;
        b_nan      = (opb[30:23] == 8'hFF) && (opb[22:0] != 23'd0);
    end

    // IEEE less-than on sign-magnitude values. Two zeros of either sign
    // compare equal, and any NaN operand makes the result false.
    always_comb begin
        a_lt_b = 1'b0;
        if (a_nan || b_nan) begin
            a_lt_b = 1'b0;
        end else if ((opa[30:0] == 31'd0) && (opb[30:0] == 31'd0)) begin
            a_lt_b = 1'b0;
        end else if (a_sign != b_sign) begin
            a_lt_b = a_sign;
        end else if (!a_sign) begin
            a_lt_b = (opa[30:0] < opb[30:0]);
        end else begin
            a_lt_b = (opa[30:0] > opb[30:0]);
        end
    end

    // Next-state, result and register-file update
    logic [31:0] result;
    logic        wr_en;

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        cond_d     = cond_q;
        out_data_d = out_data_q;
        regs_d     = regs_q;
        result     = '0;
        wr_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                    case (operation)
                        FPU_OPSET: begin
                            result = in_data;
                            wr_en  = 1'b1;
                        end
                        FPU_OPFINV_INIT: begin
                            wr_en = 1'b1;
                            if (a_nan)           result = QNAN;
                            else if (a_exp_zero) result = {a_sign, 31'd0} | POS_INF;
                            else if (a_inf)      result = {a_sign, 31'd0};
                            else                 result = {a_sign, 31'd0} |
                                                          (32'h7EF3_11C3 - {1'b0, opa[30:0]});
                        end
                        FPU_OPSQRT_INV_INIT: begin
                            wr_en = 1'b1;
                            if (a_exp_zero)          result = POS_INF;
                            else if (a_nan || a_sign) result = QNAN;
                            else if (a_inf)          result = 32'd0;
                            else                     result = 32'h5F37_59DF - {1'b0, opa[31:1]};
                        end
                        FPU_OPSQRT_INIT: begin
                            wr_en = 1'b1;
                            if (a_exp_zero)          result = {a_sign, 31'd0};
                            else if (a_nan || a_sign) result = QNAN;
                            else if (a_inf)          result = POS_INF;
                            else                     result = 32'h1FBD_1DF5 + {1'b0, opa[31:1]};
                        end
                        FPU_OPFCLT: begin
                            cond_d = a_lt_b;
                            result = {31'd0, a_lt_b};
                        end
                        FPU_OPFCZ: begin
                            cond_d = (opa[30:0] == 31'd0);
                            result = {31'd0, (opa[30:0] == 31'd0)};
                        end
                        default: begin
                            result = '0;
                        end
                    endcase
                    out_data_d = result;
`ifdef FPU_ZERO_REG_EN
                    if (wr_en && (y != 5'd0)) regs_d[y] = result;
`else
                    if (wr_en) regs_d[y] = result;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            cond_q     <= 1'b0;
            out_data_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cond_q     <= cond_d;
            out_data_q <= out_data_d;
            regs_q     <= regs_d;
        end
    end

    assign valid    = valid_q;
    assign out_data = out_data_q;
    assign cond     = cond_q;

endmodule

// File: tb/tb_fpu_core.sv
module tb_fpu_core;

    localparam logic [5:0] OP_FCLT    = 6'b000100;
    localparam logic [5:0] OP_FCZ     = 6'b000101;
    localparam logic [5:0] OP_FINV    = 6'b010000;
    localparam logic [5:0] OP_SQRT    = 6'b010001;
    localparam logic [5:0] OP_SQRTINV = 6'b010010;
    localparam logic [5:0] OP_SET     = 6'b111110;
    localparam logic [5:0] OP_BAD     = 6'b000000;

    logic        clk;
    logic        rstn;
    logic [4:0]  x1, x2, y;
    logic [5:0]  operation;
    logic [31:0] in_data;
    logic        ready;
    logic        valid;
    logic [31:0] out_data;
    logic        cond;

    int checks;
    int failures;

    fpu_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .y         (y),
        .operation (operation),
        .in_data   (in_data),
        .ready     (ready),
        .valid     (valid),
        .out_data  (out_data),
        .cond      (cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] exp_out;
        logic        exp_cond;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Issue one op. Inputs are driven at a negedge, ready is dropped just
    // after the accepting edge, and outputs are sampled at the next negedge.
    task automatic do_op(input string name, input logic [5:0] op, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] dst, input logic [31:0] data,
                         input logic [31:0] exp_out, input logic exp_cond);
        @(negedge clk);
        operation = op; x1 = a1; x2 = a2; y = dst; in_data = data; ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        operation = 'x; x1 = 'x; x2 = 'x; y = 'x; in_data = 'x;
        @(negedge clk);
        check1({name, ".valid"}, valid, 1'b1);
        check32({name, ".out"}, out_data, exp_out);
        check1({name, ".cond"}, cond, exp_cond);
        @(negedge clk);
        check1({name, ".valid_drop"}, valid, 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        ready = 1'b0;
        operation = 'x; x1 = 'x; x2 = 'x; y = 'x; in_data = 'x;

        //                 op          x1    x2    y     in_data        out            cond
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd1, 32'h3F800000, 32'h3F800000, 1'b0});
        vecs.push_back('{OP_FCZ,     5'd0, 5'd0, 5'd0, 32'h0,        32'h00000001, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd0, 32'h40800000, 32'h40800000, 1'b1});
        vecs.push_back('{OP_SQRTINV, 5'd0, 5'd0, 5'd1, 32'h0,        32'h3EF759DF, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{OP_SQRTINV, 5'd0, 5'd0, 5'd2, 32'h0,        32'h7F800000, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd1, 32'h3F800000, 32'h3F800000, 1'b1});
        vecs.push_back('{OP_FINV,    5'd1, 5'd0, 5'd3, 32'h0,        32'h3F7311C3, 1'b1});
        vecs.push_back('{OP_SQRT,    5'd1, 5'd0, 5'd3, 32'h0,        32'h3F7D1DF5, 1'b1});
        vecs.push_back('{OP_SQRT,    5'd0, 5'd0, 5'd3, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd0, 32'h40000000, 32'h40000000, 1'b1});
        vecs.push_back('{OP_FCLT,    5'd0, 5'd1, 5'd0, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{OP_FCLT,    5'd1, 5'd0, 5'd0, 32'h0,        32'h00000001, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd0, 32'h80000000, 32'h80000000, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd1, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{OP_FCLT,    5'd0, 5'd1, 5'd0, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{OP_FCLT,    5'd1, 5'd0, 5'd0, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd0, 32'h3FD9999A, 32'h3FD9999A, 1'b0});
        vecs.push_back('{OP_FCZ,     5'd0, 5'd0, 5'd0, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{OP_FCZ,     5'd0, 5'd0, 5'd0, 32'h0,        32'h00000001, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd2, 32'h12345678, 32'h12345678, 1'b1});
        vecs.push_back('{OP_BAD,     5'd2, 5'd0, 5'd2, 32'hDEADBEEF, 32'h00000000, 1'b1});
        vecs.push_back('{OP_FCZ,     5'd2, 5'd0, 5'd0, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{OP_FCZ,     5'd0, 5'd0, 5'd0, 32'h0,        32'h00000001, 1'b1});
        // special operands
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd4, 32'hFF800000, 32'hFF800000, 1'b1});
        vecs.push_back('{OP_FINV,    5'd4, 5'd0, 5'd3, 32'h0,        32'h80000000, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd4, 32'h80000001, 32'h80000001, 1'b1});
        vecs.push_back('{OP_FINV,    5'd4, 5'd0, 5'd3, 32'h0,        32'hFF800000, 1'b1});
        vecs.push_back('{OP_SQRT,    5'd4, 5'd0, 5'd3, 32'h0,        32'h80000000, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd4, 32'hC0000000, 32'hC0000000, 1'b1});
        vecs.push_back('{OP_SQRT,    5'd4, 5'd0, 5'd3, 32'h0,        32'h7FC00000, 1'b1});
        vecs.push_back('{OP_SQRTINV, 5'd4, 5'd0, 5'd3, 32'h0,        32'h7FC00000, 1'b1});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd5, 32'h7FC00001, 32'h7FC00001, 1'b1});
        vecs.push_back('{OP_FINV,    5'd5, 5'd0, 5'd3, 32'h0,        32'h7FC00000, 1'b1});
        vecs.push_back('{OP_FCLT,    5'd1, 5'd5, 5'd0, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd6, 32'h7F800000, 32'h7F800000, 1'b0});
        vecs.push_back('{OP_SQRTINV, 5'd6, 5'd0, 5'd3, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{OP_SQRT,    5'd6, 5'd0, 5'd3, 32'h0,        32'h7F800000, 1'b0});
        vecs.push_back('{OP_FINV,    5'd6, 5'd0, 5'd3, 32'h0,        32'h00000000, 1'b0});
        // negative-number ordering: -2.0 < -1.0
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd7, 32'hBF800000, 32'hBF800000, 1'b0});
        vecs.push_back('{OP_SET,     5'd0, 5'd0, 5'd8, 32'hC0000000, 32'hC0000000, 1'b0});
        vecs.push_back('{OP_FCLT,    5'd8, 5'd7, 5'd0, 32'h0,        32'h00000001, 1'b1});
        vecs.push_back('{OP_FCLT,    5'd7, 5'd8, 5'd0, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{OP_FCLT,    5'd8, 5'd6, 5'd0, 32'h0,        32'h00000001, 1'b1});

        repeat (3) @(negedge clk);
        check1("reset.valid", valid, 1'b0);
        check32("reset.out", out_data, 32'h0);
        check1("reset.cond", cond, 1'b0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check1("idle_no_ready.valid", valid, 1'b0);

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a1, vecs[i].a2,
                  vecs[i].dst, vecs[i].data, vecs[i].exp_out, vecs[i].exp_cond);
        end

        // ready held high across four cycles: only the ops presented in
        // IDLE cycles (first and third) execute.
        @(negedge clk);
        ready = 1'b1; operation = OP_SET; y = 5'd9; x1 = 5'd0; x2 = 5'd0;
        in_data = 32'h3F000000;
        @(negedge clk);
        check1("b2b.valid0", valid, 1'b1);
        check32("b2b.out0", out_data, 32'h3F000000);
        in_data = 32'h40800000;
        @(negedge clk);
        check1("b2b.valid1", valid, 1'b0);
        in_data = 32'h40000000;
        @(negedge clk);
        check1("b2b.valid2", valid, 1'b1);
        check32("b2b.out2", out_data, 32'h40000000);
        in_data = 32'h41000000;
        @(negedge clk);
        check1("b2b.valid3", valid, 1'b0);
        ready = 1'b0;
        operation = 'x; x1 = 'x; x2 = 'x; y = 'x; in_data = 'x;
        repeat (2) @(negedge clk);
        check1("b2b.no_extra_op", valid, 1'b0);
        check32("b2b.out_hold", out_data, 32'h40000000);
        // reg9 must hold 2.0 -> sqrt seed 0x1FBD1DF5 + 0x20000000
        do_op("b2b.reg9", OP_SQRT, 5'd9, 5'd0, 5'd3, 32'h0, 32'h3FBD1DF5, 1'b1);

        // Reset while in DONE: valid and outputs clear at once, registers clear.
        @(negedge clk);
        ready = 1'b1; operation = OP_SET; y = 5'd10; in_data = 32'h40400000;
        x1 = 5'd0; x2 = 5'd0;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check1("rst_done.valid_before", valid, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        check1("rst_done.valid", valid, 1'b0);
        check32("rst_done.out", out_data, 32'h0);
        check1("rst_done.cond", cond, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        do_op("rst_done.reg10", OP_SQRT, 5'd10, 5'd0, 5'd3, 32'h0, 32'h00000000, 1'b0);
        do_op("rst_done.reg9", OP_FCZ, 5'd9, 5'd0, 5'd0, 32'h0, 32'h00000001, 1'b1);
        do_op("rst_done.reg7", OP_FCZ, 5'd7, 5'd0, 5'd0, 32'h0, 32'h00000001, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_core.md
Name: fpu_core

Overview:
- Register-file floating-point helper unit: 32 x 32-bit IEEE-754 single-precision registers, selected by 5-bit addresses x1/x2/y.
- Executes one operation per ready/valid handshake:
  - immediate load (SET);
  - Newton-iteration seed generators for reciprocal, sqrt and inverse sqrt;
  - compares that drive a condition flag.
- Sits beside the CPU core as a coprocessor; the core issues ops and waits for valid.

Parameters:
- none (all opcodes are fixed constants in the shared FPU params header)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- x1  in  5  source register 1 address
- x2  in  5  source register 2 address
- y  in  5  destination register address
- operation  in  6  opcode
- in_data  in  32  immediate for SET
- ready  in  1  request: operands/opcode valid
- valid  out  1  one-cycle completion pulse
- out_data  out  32  result of last op
- cond  out  1  result of last compare

Behaviour:
- Opcodes:
  - FPU_OPFCLT=6'b000100
  - FPU_OPFCZ=6'b000101
  - FPU_OPFINV_INIT=6'b010000
  - FPU_OPSQRT_INIT=6'b010001
  - FPU_OPSQRT_INV_INIT=6'b010010
  - FPU_OPSET=6'b111110
  - any other opcode: no register write, cond unchanged, out_data=0, valid still pulses.
- Reset (async, rstn=0): all 32 registers=0, out_data=0, cond=0, valid=0, FSM=IDLE. Reset mid-operation aborts it and no write occurs.
- FSM IDLE/DONE:
  - IDLE with ready=1 at rising edge: latch op, compute, write register, update out_data/cond, valid<=1, go DONE.
  - DONE: valid<=0, ready ignored, return to IDLE.
  - Latency: valid high exactly one cycle after the accepting edge. Minimum issue interval is 2 cycles.
  - ready held high after valid re-issues whatever inputs are present in the next IDLE cycle.
- Register read of reg[x1]/reg[x2] sees the pre-write value; no same-cycle forwarding is needed, because there is one op per 2 cycles.
- SET: reg[y]<=in_data; out_data=in_data.
- FINV_INIT (a=reg[x1]), result to reg[y] and out_data:
  - exp==0 (zero/denormal): sign|0x7F800000.
  - Inf: sign|0.
  - NaN: 0x7FC00000.
  - else: sign | (0x7EF311C3 - |a|).
- SQRT_INV_INIT:
  - zero/denormal: 0x7F800000.
  - negative nonzero or NaN: 0x7FC00000.
  - +Inf: 0.
  - else: 0x5F3759DF - (a>>1).
- SQRT_INIT:
  - zero/denormal: sign|0.
  - negative or NaN: 0x7FC00000.
  - +Inf: 0x7F800000.
  - else: 0x1FBD1DF5 + (a>>1).
- FCLT: cond = (reg[x1] < reg[x2]) as IEEE values.
  - +0 and -0 are equal.
  - Any NaN operand gives cond=0.
  - out_data={31'b0,cond}; no register write.
- FCZ: cond = (reg[x1][30:0]==0), i.e. ±0 is zero. out_data={31'b0,cond}; no register write.
- Init/SET ops leave cond unchanged.
- Undefined inputs (x) while ready=0 must not change state.

Optional Feature:
- Macro FPU_ZERO_REG_EN.
  - Defined: register 0 is hardwired to +0. Writes to y=0 are discarded, but valid and out_data still reflect the computed value. Reads of address 0 return 0.
  - Undefined (default): register 0 is an ordinary register.

Test Plan:
- Reset then SET y=1, in_data=0x3F800000 -> valid one cycle later, out_data=0x3F800000, reg[1]=0x3F800000; reg[0] still 0.
- SET r0=0x40800000 (4.0), SQRT_INV_INIT x1=0,y=1 -> reg[1]=0x3EF759DF. Then SQRT_INV_INIT on 0 -> 0x7F800000.
- r1=1.0: FINV_INIT x1=1 -> 0x3F7311C3; SQRT_INIT x1=1 -> 0x3F7D1DF5; SQRT_INIT on 0 -> 0x00000000.
- r0=2.0, r1=1.0: FCLT x1=0,x2=1 -> cond=0; FCLT x1=1,x2=0 -> cond=1; r0=-0, r1=+0 -> cond=0.
- FCZ on r0=0x3FD9999A (1.7) -> cond=0. FCZ after SET r0=0 -> cond=1. A following SET leaves cond=1.
- ready held high across four ops on consecutive cycles -> valid pulses every other cycle; only ops presented in IDLE cycles execute. Assert rstn=0 during DONE -> valid drops immediately and registers clear.
